fifo_flex: RTL and testbench

FIFO_FLEX -- requirements
Module: fifo_flex

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ram.sv | 29 ++
 rtl/fifo_flex.sv | 102 ++++++++++
 tb/tb_fifo_flex.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO mode constants and count-width helper
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // count must be able to represent DEPTH itself, not just DEPTH-1
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_WIDTH storage, one write port, one synchronous read port
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // only the read register is reset; a same-edge write to raddr returns the old word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - synchronous FIFO with registered-read or first-word-fall-through output
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int FWFT       = FIFO_STD,
  parameter int AE_THRESH  = 1,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr,
  input  logic                        WR,
  input  logic [DATA_WIDTH-1:0]       dataIn,
  input  logic                        RD,
  output logic [DATA_WIDTH-1:0]       dataOut,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0]         wptr, rptr, rptr_nxt, ram_raddr;
  logic                  rd_acc, wr_acc, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata, byp_data;
  logic                  byp_sel;

  assign rd_acc   = RD && !empty && !clr;
  assign wr_acc   = WR && (!full || rd_acc) && !clr;
  assign rptr_nxt = rd_acc ? rptr + AW'(1) : rptr;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      byp_sel   <= 1'b0;
      byp_data  <= '0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      byp_sel   <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      rptr <= rptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (WR && full && !RD) overflow  <= 1'b1;
      if (RD && empty)       underflow <= 1'b1;
      // word written this edge becomes the head: RAM read sees the old cell, so bypass it
      byp_sel <= wr_acc && (wptr == rptr_nxt);
      if (wr_acc) byp_data <= dataIn;
    end
  end

  // FWFT pre-fetches the next head every cycle; registered mode fetches only on a pop
  assign ram_re    = (FWFT == FIFO_FWFT) ? 1'b1 : rd_acc;
  assign ram_raddr = (FWFT == FIFO_FWFT) ? rptr_nxt : rptr;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (dataIn),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    dataOut = ram_rdata;
    if (FWFT == FIFO_FWFT) begin
      if (empty)        dataOut = '0;
      else if (byp_sel) dataOut = byp_data;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - self-checking bench for fifo_flex in both output modes
module tb_fifo_flex;

  logic       clk, rstn, clr, WR, RD;
  logic [7:0] dataIn;

  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s, ov_s, un_s;
  logic       full_f, empty_f, af_f, ae_f, ov_f, un_f;
  logic [2:0] cnt_s, cnt_f;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  logic       m_ov, m_un;
  logic [7:0] m_dstd;

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0), .AE_THRESH(1), .AF_THRESH(3)) u_std (
    .clk(clk), .rstn(rstn), .clr(clr), .WR(WR), .dataIn(dataIn), .RD(RD),
    .dataOut(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(cnt_s), .overflow(ov_s), .underflow(un_s)
  );

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AE_THRESH(1), .AF_THRESH(3)) u_fwft (
    .clk(clk), .rstn(rstn), .clr(clr), .WR(WR), .dataIn(dataIn), .RD(RD),
    .dataOut(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ov_f), .underflow(un_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov   = 1'b0;
    m_un   = 1'b0;
    m_dstd = 8'h00;
  endtask

  task automatic model_edge();
    bit rd, wr;
    int n;
    n = mq.size();
    if (!rstn) begin
      model_reset();
    end else if (clr) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      rd = RD && (n > 0);
      wr = WR && ((n < 4) || rd);
      if (RD && n == 0)          m_un = 1'b1;
      if (WR && n == 4 && !RD)   m_ov = 1'b1;
      if (rd) m_dstd = mq.pop_front();
      if (wr) mq.push_back(dataIn);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count_std",  32'(cnt_s),   32'(n));
    chk("count_fwft", 32'(cnt_f),   32'(n));
    chk("full_std",   32'(full_s),  32'(n == 4));
    chk("full_fwft",  32'(full_f),  32'(n == 4));
    chk("empty_std",  32'(empty_s), 32'(n == 0));
    chk("empty_fwft", 32'(empty_f), 32'(n == 0));
    chk("af_std",     32'(af_s),    32'(n >= 3));
    chk("af_fwft",    32'(af_f),    32'(n >= 3));
    chk("ae_std",     32'(ae_s),    32'(n <= 1));
    chk("ae_fwft",    32'(ae_f),    32'(n <= 1));
    chk("ovf_std",    32'(ov_s),    32'(m_ov));
    chk("ovf_fwft",   32'(ov_f),    32'(m_ov));
    chk("unf_std",    32'(un_s),    32'(m_un));
    chk("unf_fwft",   32'(un_f),    32'(m_un));
    chk("dout_std",   32'(dout_s),  32'(m_dstd));
    if (n > 0) chk("dout_fwft", 32'(dout_f), 32'(mq[0]));
  endtask

  // called just after a falling edge: drive, let the rising edge pass, check at the next fall
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    WR = w; RD = r; dataIn = d; clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    chk("rst_count", 32'(cnt_s), 32'd0);
    chk("rst_empty", 32'(empty_f), 32'd1);
    chk("rst_dout_fwft", 32'(dout_f), 32'd0);
    rstn = 1'b1;

    // fill 0..3 and watch thresholds
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      chk("fill_count", 32'(cnt_s), 32'(i + 1));
      chk("fill_ae", 32'(ae_s), 32'(i == 0));
      chk("fill_af", 32'(af_f), 32'(i >= 2));
      chk("fill_full", 32'(full_s), 32'(i == 3));
    end
    chk("fwft_head_full", 32'(dout_f), 32'd0);

    step(1'b1, 1'b0, 8'd9, 1'b0);
    chk("ovf_set", 32'(ov_s), 32'd1);
    chk("ovf_count", 32'(cnt_f), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_std", 32'(dout_s), 32'(i));
    end
    chk("drain_empty", 32'(empty_s), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", 32'(ov_f), 32'd0);

    // FWFT write into empty
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("fwft_a5", 32'(dout_f), 32'hA5);
    chk("fwft_a5_empty", 32'(empty_f), 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_pop_empty", 32'(empty_f), 32'd1);
    chk("fwft_pop_unf", 32'(un_f), 32'd0);

    // simultaneous push/pop while full
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'd10 + 8'(i)), 1'b0);
    step(1'b1, 1'b1, 8'd7, 1'b0);
    chk("pp_full_count", 32'(cnt_s), 32'd4);
    chk("pp_full_ovf", 32'(ov_s), 32'd0);
    chk("pp_full_dout", 32'(dout_s), 32'd10);
    chk("pp_fwft_head", 32'(dout_f), 32'd11);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk("pp_rd0", 32'(dout_s), 32'd11);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk("pp_rd1", 32'(dout_s), 32'd12);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk("pp_rd2", 32'(dout_s), 32'd13);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk("pp_rd3", 32'(dout_s), 32'd7);

    // underflow
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf_set", 32'(un_s), 32'd1);
    chk("unf_count", 32'(cnt_s), 32'd0);
    chk("unf_dout_hold", 32'(dout_s), 32'd7);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    chk("unf_wr_count", 32'(cnt_f), 32'd1);
    chk("unf_sticky", 32'(un_f), 32'd1);
    chk("unf_wr_fwft", 32'(dout_f), 32'h33);

    // clr with 3 words
    step(1'b1, 1'b0, 8'h44, 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_count", 32'(cnt_s), 32'd0);
    chk("clr_empty", 32'(empty_f), 32'd1);
    chk("clr_unf", 32'(un_s), 32'd0);
    chk("clr_dout_std", 32'(dout_s), 32'd7);
    chk("clr_dout_fwft", 32'(dout_f), 32'd0);

    // asynchronous reset mid-write
    step(1'b1, 1'b0, 8'h61, 1'b0);
    step(1'b1, 1'b0, 8'h62, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    WR = 1'b1; RD = 1'b0; dataIn = 8'h63;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("arst_count", 32'(cnt_f), 32'd0);
    chk("arst_dout_std", 32'(dout_s), 32'd0);
    chk("arst_dout_fwft", 32'(dout_f), 32'd0);
    chk("arst_ae", 32'(ae_s), 32'd1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b0, 8'h5C, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_first", 32'(dout_s), 32'h5C);

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = ((i / 250) % 2 == 1) ? 75 : 30;
      step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < (100 - pw)),
           8'($urandom), 1'($urandom_range(199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
